// File: rtl/plab5_mcore_dma_cmd_queue.sv
// DMA command queue: FIFO of copy commands issued one at a time to the DMA controller with tagged completions; PLAB5_MCORE_DMA_CMDQ_TIMEOUT_EN adds a BUSY watchdog.
// Latency: accept to dma_val 2 cycles into an idle empty queue; dma_ack to done_val 1 cycle.
// Backpressure: cmd_rdy drops when full (no same-cycle refill); dma_rdy stalls the head; done_rdy stalls the next issue.

module plab5_mcore_dma_cmd_queue_fifo #(
    parameter int p_width = 8,
    parameter int p_depth = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_vld,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_dat,
    output logic               deq_vld,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_dat
);
    localparam int c_ptr_nbits = $clog2(p_depth);

    logic [p_width-1:0]     mem [p_depth];
    logic [c_ptr_nbits-1:0] wr_ptr;
    logic [c_ptr_nbits-1:0] rd_ptr;
    logic [c_ptr_nbits:0]   count;
    logic                   enq;
    logic                   deq;

    // Readiness comes from the registered count only, so a pop cannot make room in the same cycle.
    assign enq_rdy = (count != (c_ptr_nbits+1)'(p_depth));
    assign deq_vld = (count != '0);
    assign enq     = enq_vld && enq_rdy;
    assign deq     = deq_vld && deq_rdy;
    assign deq_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            if (enq && !deq)      count <= count + 1'b1;
            else if (deq && !enq) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= enq_dat;
    end
endmodule

module plab5_mcore_dma_cmd_queue #(
    parameter int  p_opaque_nbits   = 8,
    parameter int  p_addr_nbits     = 32,
    parameter int  p_data_nbits     = 32,
    parameter int  p_num_entries    = 4,
    parameter int  p_timeout_cycles = 256,
    // Memory request message minus its data field: type(3) + opaque + addr + len.
    localparam int c_req_cnbits     = 3 + p_opaque_nbits + p_addr_nbits + $clog2(p_data_nbits/8)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_val,
    output logic                    cmd_rdy,
    input  logic                    cmd_domain,
    input  logic [p_addr_nbits-1:0] cmd_src_addr,
    input  logic [p_addr_nbits-1:0] cmd_dest_addr,
    input  logic [c_req_cnbits-1:0] cmd_control,
    output logic                    dma_val,
    input  logic                    dma_rdy,
    output logic                    dma_domain,
    output logic [p_addr_nbits-1:0] dma_src_addr,
    output logic [p_addr_nbits-1:0] dma_dest_addr,
    output logic [c_req_cnbits-1:0] dma_req_control,
    input  logic                    dma_ack,
    output logic                    done_val,
    input  logic                    done_rdy,
    output logic                    done_domain,
    output logic [7:0]              done_tag,
    output logic                    done_status
);
    if (p_num_entries < 2 || (p_num_entries & (p_num_entries - 1)) != 0) begin : g_bad_depth
        $error("p_num_entries must be a power of two >= 2");
    end
    if (p_timeout_cycles < 1) begin : g_bad_timeout
        $error("p_timeout_cycles must be >= 1");
    end

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_ISSUE = 2'd1;
    localparam logic [1:0] STATE_BUSY  = 2'd2;
    localparam logic [1:0] STATE_DONE  = 2'd3;

    typedef struct packed {
        logic                    domain;
        logic [7:0]              tag;
        logic [p_addr_nbits-1:0] src_addr;
        logic [p_addr_nbits-1:0] dest_addr;
        logic [c_req_cnbits-1:0] control;
    } entry_t;

    entry_t     enq_entry;
    entry_t     head;
    logic       head_vld;
    logic [1:0] state;
    logic [7:0] tag_ctr;
    logic       fly_domain;
    logic [7:0] fly_tag;
    logic       issue;
    logic       expire;

    assign enq_entry = '{domain:    cmd_domain,
                         tag:       tag_ctr,
                         src_addr:  cmd_src_addr,
                         dest_addr: cmd_dest_addr,
                         control:   cmd_control};

    plab5_mcore_dma_cmd_queue_fifo #(
        .p_width ($bits(entry_t)),
        .p_depth (p_num_entries)
    ) cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .enq_vld (cmd_val),
        .enq_rdy (cmd_rdy),
        .enq_dat (enq_entry),
        .deq_vld (head_vld),
        .deq_rdy (issue),
        .deq_dat (head)
    );

    assign issue = (state == STATE_ISSUE) && dma_rdy;

    always_ff @(posedge clk) begin
        if (reset)                  tag_ctr <= '0;
        else if (cmd_val && cmd_rdy) tag_ctr <= tag_ctr + 1'b1;
    end

`ifdef PLAB5_MCORE_DMA_CMDQ_TIMEOUT_EN
    localparam int c_tmr_nbits = $clog2(p_timeout_cycles) + 1;

    logic [c_tmr_nbits-1:0] timer;
    logic                   status_q;

    // timer holds the number of BUSY cycles already completed.
    assign expire = (state == STATE_BUSY) && (timer == c_tmr_nbits'(p_timeout_cycles - 1));

    always_ff @(posedge clk) begin
        if (reset)                     timer <= '0;
        else if (issue)                timer <= '0;
        else if (state == STATE_BUSY)  timer <= timer + 1'b1;
    end

    // An ack arriving in the expiry cycle still reports success.
    always_ff @(posedge clk) begin
        if (reset)
            status_q <= 1'b0;
        else if (state == STATE_BUSY && (dma_ack || expire))
            status_q <= !dma_ack;
    end

    assign done_status = status_q;
`else
    assign expire      = 1'b0;
    assign done_status = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= STATE_IDLE;
            fly_domain  <= 1'b0;
            fly_tag     <= '0;
            done_domain <= 1'b0;
            done_tag    <= '0;
        end else begin
            case (state)
                STATE_IDLE:  if (head_vld) state <= STATE_ISSUE;
                STATE_ISSUE: if (dma_rdy) begin
                    fly_domain <= head.domain;
                    fly_tag    <= head.tag;
                    state      <= STATE_BUSY;
                end
                STATE_BUSY:  if (dma_ack || expire) begin
                    done_domain <= fly_domain;
                    done_tag    <= fly_tag;
                    state       <= STATE_DONE;
                end
                STATE_DONE:  if (done_rdy) state <= STATE_IDLE;
                default:     state <= STATE_IDLE;
            endcase
        end
    end

    assign dma_val         = (state == STATE_ISSUE);
    assign dma_domain      = dma_val ? head.domain    : 1'b0;
    assign dma_src_addr    = dma_val ? head.src_addr  : '0;
    assign dma_dest_addr   = dma_val ? head.dest_addr : '0;
    assign dma_req_control = dma_val ? head.control   : '0;
    assign done_val        = (state == STATE_DONE);
endmodule

// File: tb/tb_plab5_mcore_dma_cmd_queue.sv
// Bench for plab5_mcore_dma_cmd_queue: directed latency/boundary cases plus a randomized run
// scored against a queue-based model of accepted, issued and completed commands.
module tb_plab5_mcore_dma_cmd_queue;
    localparam int CW  = 45;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_val, cmd_rdy, cmd_domain;
    logic [31:0]   cmd_src_addr, cmd_dest_addr;
    logic [CW-1:0] cmd_control;
    logic          dma_val, dma_rdy, dma_domain;
    logic [31:0]   dma_src_addr, dma_dest_addr;
    logic [CW-1:0] dma_req_control;
    logic          dma_ack;
    logic          done_val, done_rdy, done_domain, done_status;
    logic [7:0]    done_tag;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          dom;
        logic [7:0]    tag;
        logic [31:0]   src;
        logic [31:0]   dest;
        logic [CW-1:0] ctl;
    } cmd_t;

    plab5_mcore_dma_cmd_queue #(
        .p_num_entries    (4),
        .p_timeout_cycles (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_val         (cmd_val),
        .cmd_rdy         (cmd_rdy),
        .cmd_domain      (cmd_domain),
        .cmd_src_addr    (cmd_src_addr),
        .cmd_dest_addr   (cmd_dest_addr),
        .cmd_control     (cmd_control),
        .dma_val         (dma_val),
        .dma_rdy         (dma_rdy),
        .dma_domain      (dma_domain),
        .dma_src_addr    (dma_src_addr),
        .dma_dest_addr   (dma_dest_addr),
        .dma_req_control (dma_req_control),
        .dma_ack         (dma_ack),
        .done_val        (done_val),
        .done_rdy        (done_rdy),
        .done_domain     (done_domain),
        .done_tag        (done_tag),
        .done_status     (done_status)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cmd_val = 1'b0; dma_rdy = 1'b0; dma_ack = 1'b0; done_rdy = 1'b0;
        cmd_domain = 1'b0; cmd_src_addr = '0; cmd_dest_addr = '0; cmd_control = '0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic set_cmd(input logic dom, input logic [31:0] src, input logic [31:0] dest);
        cmd_val       = 1'b1;
        cmd_domain    = dom;
        cmd_src_addr  = src;
        cmd_dest_addr = dest;
        cmd_control   = CW'({$urandom, $urandom});
    endtask

    task automatic wait_dma(input string nm, output bit ok);
        int w = 0;
        while (!dma_val && w < 20) begin
            tick;
            w++;
        end
        ok = dma_val;
        if (!ok) chk({nm, "_issue_timeout"}, 64'(dma_val), 64'(1));
    endtask

    // Issue, ack and retire one command, checking the head and the completion it produces.
    task automatic serve_one(input string nm, input logic dom, input logic [31:0] src, input logic [7:0] tag);
        bit ok;
        wait_dma(nm, ok);
        if (!ok) return;
        chk({nm, "_src"}, 64'(dma_src_addr), 64'(src));
        chk({nm, "_dom"}, 64'(dma_domain), 64'(dom));
        dma_rdy = 1'b1; tick; dma_rdy = 1'b0;
        dma_ack = 1'b1; tick; dma_ack = 1'b0;
        chk({nm, "_done_val"}, 64'(done_val), 64'(1));
        chk({nm, "_done_tag"}, 64'(done_tag), 64'(tag));
        chk({nm, "_done_dom"}, 64'(done_domain), 64'(dom));
        chk({nm, "_done_status"}, 64'(done_status), 64'(0));
        done_rdy = 1'b1; tick; done_rdy = 1'b0;
    endtask

    initial begin
        bit ok;
        int n;
        logic [CW-1:0] ctl0;
        cmd_t pend[$];
        cmd_t fly;
        cmd_t c;
        bit outstanding, acked, accept, issue;
        int busy_wait, tag_next, done_cnt, cyc;

        // ---- reset state
        do_reset;
        chk("rst_cmd_rdy",  64'(cmd_rdy), 64'(1));
        chk("rst_dma_val",  64'(dma_val), 64'(0));
        chk("rst_dma_src",  64'(dma_src_addr), 64'(0));
        chk("rst_done_val", 64'(done_val), 64'(0));
        chk("rst_done_tag", 64'(done_tag), 64'(0));
        chk("rst_done_dom", 64'(done_domain), 64'(0));
        chk("rst_done_sts", 64'(done_status), 64'(0));

        // ---- single command latency
        set_cmd(1'b1, 32'h1000, 32'h2000);
        ctl0 = cmd_control;
        dma_rdy = 1'b1;
        tick;
        cmd_val = 1'b0;
        chk("single_n1_dma_val", 64'(dma_val), 64'(0));
        tick;
        chk("single_n2_dma_val", 64'(dma_val), 64'(1));
        chk("single_src",  64'(dma_src_addr), 64'(32'h1000));
        chk("single_dest", 64'(dma_dest_addr), 64'(32'h2000));
        chk("single_dom",  64'(dma_domain), 64'(1));
        chk("single_ctl",  64'(dma_req_control), 64'(ctl0));
        tick;
        dma_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick;
            chk("single_wait_done", 64'(done_val), 64'(0));
        end
        dma_ack = 1'b1; tick; dma_ack = 1'b0;
        chk("single_done_val", 64'(done_val), 64'(1));
        chk("single_done_tag", 64'(done_tag), 64'(0));
        chk("single_done_dom", 64'(done_domain), 64'(1));
        chk("single_done_sts", 64'(done_status), 64'(0));
        done_rdy = 1'b1; tick; done_rdy = 1'b0;
        chk("single_done_drop", 64'(done_val), 64'(0));
        chk("single_hold_tag",  64'(done_tag), 64'(0));
        chk("single_hold_dom",  64'(done_domain), 64'(1));

        // ---- fill to full, refused enqueue on the issue cycle
        do_reset;
        for (int i = 0; i < 4; i++) begin
            chk("fill_rdy", 64'(cmd_rdy), 64'(1));
            set_cmd(1'(i), 32'h100 * 32'(i + 1), 32'h9000 + 32'(i));
            tick;
        end
        chk("fill_full", 64'(cmd_rdy), 64'(0));
        set_cmd(1'b0, 32'h500, 32'h9004);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("fill_hold_rdy", 64'(cmd_rdy), 64'(0));
        end
        chk("fill_head_src", 64'(dma_src_addr), 64'(32'h100));
        dma_rdy = 1'b1; tick; dma_rdy = 1'b0;
        chk("fill_refused", 64'(cmd_rdy), 64'(1));
        chk("fill_busy_dma", 64'(dma_val), 64'(0));
        tick;
        cmd_val = 1'b0;
        chk("fill_5th_in", 64'(cmd_rdy), 64'(0));
        dma_ack = 1'b1; tick; dma_ack = 1'b0;
        chk("fill_tag0", 64'(done_tag), 64'(0));
        done_rdy = 1'b1; tick; done_rdy = 1'b0;
        for (int k = 1; k < 5; k++)
            serve_one("fill", 1'(k % 2), 32'h100 * 32'(k + 1), 8'(k));

        // ---- completion backpressure
        do_reset;
        set_cmd(1'b0, 32'hA0, 32'hA1); tick;
        set_cmd(1'b1, 32'hB0, 32'hB1); tick;
        cmd_val = 1'b0;
        wait_dma("bp", ok);
        dma_rdy = 1'b1; tick; dma_rdy = 1'b0;
        dma_ack = 1'b1; tick; dma_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("bp_done_held", 64'(done_val), 64'(1));
            chk("bp_tag_stable", 64'(done_tag), 64'(0));
            chk("bp_no_issue", 64'(dma_val), 64'(0));
            tick;
        end
        done_rdy = 1'b1; tick; done_rdy = 1'b0;
        chk("bp_k1_idle", 64'(dma_val), 64'(0));
        tick;
        chk("bp_k2_issue", 64'(dma_val), 64'(1));
        serve_one("bp2", 1'b1, 32'hB0, 8'd1);

        // ---- reset while BUSY with three queued
        do_reset;
        dma_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 32'h700 + 32'(i), 32'h800);
            tick;
        end
        cmd_val = 1'b0; dma_rdy = 1'b0;
        tick;
        chk("rb_busy", 64'(dma_val), 64'(0));
        reset = 1'b1; tick; reset = 1'b0;
        chk("rb_cmd_rdy",  64'(cmd_rdy), 64'(1));
        chk("rb_dma_val",  64'(dma_val), 64'(0));
        chk("rb_done_val", 64'(done_val), 64'(0));
        dma_ack = 1'b1; tick; dma_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rb_no_done", 64'(done_val), 64'(0));
            chk("rb_no_issue", 64'(dma_val), 64'(0));
            tick;
        end
        set_cmd(1'b0, 32'hC0, 32'hC1); tick; cmd_val = 1'b0;
        serve_one("rb_new", 1'b0, 32'hC0, 8'd0);

        // ---- watchdog behaviour
        do_reset;
        set_cmd(1'b1, 32'hD0, 32'hD1); tick; cmd_val = 1'b0;
        wait_dma("tmo", ok);
        dma_rdy = 1'b1; tick; dma_rdy = 1'b0;
        n = 0;
`ifdef PLAB5_MCORE_DMA_CMDQ_TIMEOUT_EN
        while (!done_val && n < 40) begin
            tick;
            n++;
        end
        chk("tmo_busy_cycles", 64'(n), 64'(TMO));
        chk("tmo_status", 64'(done_status), 64'(1));
        chk("tmo_tag", 64'(done_tag), 64'(0));
        dma_ack = 1'b1; tick; dma_ack = 1'b0;
        chk("tmo_late_ack_val", 64'(done_val), 64'(1));
        chk("tmo_late_ack_sts", 64'(done_status), 64'(1));
        done_rdy = 1'b1; tick; done_rdy = 1'b0;
        chk("tmo_retired", 64'(done_val), 64'(0));
        chk("tmo_hold_sts", 64'(done_status), 64'(1));
        dma_ack = 1'b1; tick; dma_ack = 1'b0; tick;
        chk("tmo_ack_ignored", 64'(done_val), 64'(0));
`else
        while (!done_val && n < 40) begin
            tick;
            n++;
        end
        chk("nowd_waits", 64'(done_val), 64'(0));
        dma_ack = 1'b1; tick; dma_ack = 1'b0;
        chk("nowd_done_val", 64'(done_val), 64'(1));
        chk("nowd_status", 64'(done_status), 64'(0));
        done_rdy = 1'b1; tick; done_rdy = 1'b0;
`endif

        // ---- randomized run against the queue model (covers tag wrap)
        do_reset;
        pend.delete();
        outstanding = 0; acked = 0; busy_wait = 0; tag_next = 0; done_cnt = 0; cyc = 0;
        while (done_cnt < 300 && cyc < 20000) begin
            chk("r_cmd_rdy", 64'(cmd_rdy), 64'(pend.size() != 4));
            if (outstanding) chk("r_one_outstanding", 64'(dma_val), 64'(0));
            if (dma_val) begin
                if (pend.size() == 0) begin
                    chk("r_issue_empty", 64'(dma_val), 64'(0));
                end else begin
                    chk("r_dma_src",  64'(dma_src_addr), 64'(pend[0].src));
                    chk("r_dma_dest", 64'(dma_dest_addr), 64'(pend[0].dest));
                    chk("r_dma_dom",  64'(dma_domain), 64'(pend[0].dom));
                    chk("r_dma_ctl",  64'(dma_req_control), 64'(pend[0].ctl));
                end
            end else begin
                chk("r_dma_idle_zero", 64'(dma_src_addr | dma_dest_addr), 64'(0));
            end
            chk("r_done_val", 64'(done_val), 64'(acked));
            if (acked) begin
                chk("r_done_tag", 64'(done_tag), 64'(fly.tag));
                chk("r_done_dom", 64'(done_domain), 64'(fly.dom));
                chk("r_done_sts", 64'(done_status), 64'(0));
            end

            if ($urandom_range(0, 2) != 0)
                set_cmd(1'($urandom), $urandom, $urandom);
            else
                cmd_val = 1'b0;
            accept = cmd_val && (pend.size() != 4);
            dma_rdy  = 1'($urandom);
            done_rdy = 1'($urandom);
            if (outstanding && !acked) begin
                dma_ack = (busy_wait == 0);
                if (busy_wait > 0) busy_wait--;
            end else begin
                dma_ack = ($urandom_range(0, 7) == 0);
            end

            if (outstanding && !acked && dma_ack) begin
                acked = 1;
            end else if (acked && done_rdy) begin
                if (done_cnt == 255) chk("wrap_tag_255", 64'(done_tag), 64'(255));
                if (done_cnt == 256) chk("wrap_tag_0", 64'(done_tag), 64'(0));
                outstanding = 0;
                acked = 0;
                done_cnt++;
            end
            issue = dma_val && dma_rdy && !outstanding && pend.size() != 0;
            if (issue) begin
                fly = pend.pop_front();
                outstanding = 1;
                busy_wait = $urandom_range(0, 5);
            end
            if (accept) begin
                c.dom = cmd_domain; c.tag = 8'(tag_next); c.src = cmd_src_addr;
                c.dest = cmd_dest_addr; c.ctl = cmd_control;
                pend.push_back(c);
                tag_next = (tag_next + 1) % 256;
            end
            tick;
            cyc++;
        end
        chk("r_progress", 64'(done_cnt >= 300), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
